ex_muldiv_sequencer: RTL and testbench
======================================

# ex_muldiv_sequencer

Multi-cycle controller for RV32M multiply/divide operations that issue from the execute stage. It latches the forwarded operands when an M-extension op reaches EX and holds the pipeline with a stall. It runs an iterative shift-add multiply or restoring divide and presents a single-cycle result beside the EX ALU output. It sits in parallel with the EX ALU, and the hazard/stall logic ORs its stall into the IF/ID/EX pipeline-register enables.

## Interface
Parameters:
- WIDTH, 32, operand/result width; the iteration counter is clog2(WIDTH)+1 bits.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  EX holds a valid M-extension op (control-word flag); held high while stalled.
- funct3_i  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- a_i  in  WIDTH  rs1 operand after the forwarding mux.
- b_i  in  WIDTH  rs2 operand after the forwarding mux.
- flush_i  in  1  branch mispredict/flush; kills the in-flight op.
- stall_o  out  1  freeze IF/ID/EX registers; combinational.
- done_o  out  1  one-cycle pulse; result_o valid.
- result_o  out  WIDTH  M-op result, muxed into EX_alu_out by the EX stage.

## Operation
States: IDLE, MUL, DIV, FIX, DONE (enum).
- IDLE: on start_i & !flush_i, latch a_i, b_i and funct3_i.
  - Take operand magnitudes per signedness: MULH/DIV/REM treat both operands as signed; MULHSU treats a as signed and b as unsigned.
  - Record the result sign: a^b for products and quotients, a for remainders.
  - Clear the counter.
  - Go to MUL if funct3_i[2]==0, otherwise DIV.
  - Special case, divide by zero: quotient = all ones, remainder = a. Go directly to DONE.
  - Special case, signed overflow (DIV/REM with a = 0x80000000, b = 0xFFFFFFFF): quotient = 0x80000000, remainder = 0. Go directly to DONE.
- MUL: one product bit per cycle using a 2*WIDTH accumulator (add the shifted multiplicand when the multiplier LSB is 1). Leave after WIDTH iterations → FIX.
- DIV: one restoring step per cycle (shift the remainder in, trial-subtract the divisor, set the quotient bit). Leave after WIDTH iterations → FIX.
- FIX: negate the product, quotient or remainder if its recorded sign is set. Select the result: low word for MUL, high word for MULH/MULHSU/MULHU, quotient for DIV/DIVU, remainder for REM/REMU. Register the selected value into result_o → DONE.
- DONE: done_o = 1 and stall_o = 0, so the instruction advances this cycle. start_i is ignored in DONE because it is the same instruction. Always → IDLE.
- stall_o = (IDLE & start_i & !flush_i) | MUL | DIV | FIX.
- flush_i in any state: go to IDLE at the next edge. No done_o is asserted and result_o holds its previous value. flush_i takes priority over start_i.
- Arithmetic is modulo 2^WIDTH, and negation is two's complement. MULHSU with a negative a negates the full 2*WIDTH product.

## Timing
- Reset (async assert, sync deassert at the system level): state IDLE, counter 0, result_o 0, done_o 0, stall_o 0 (given start_i = 0).
- Normal op, with cycle 0 being the IDLE cycle in which start_i is first high:
  - stall_o is high in cycles 0..WIDTH+1 (34 cycles for WIDTH = 32).
  - done_o and the valid result_o appear in cycle WIDTH+2 (cycle 34).
- Special-case divide: stall_o high in cycle 0 only; done_o in cycle 1.
- Back-to-back M-ops: the next op's start_i is seen in the cycle after DONE, which is IDLE, so there is no lost cycle beyond DONE.
- result_o stays stable until the next FIX or special-case capture.
- done_o is registered, never combinational.
- Reset mid-operation: immediate return to IDLE with all outputs cleared.

## Structure
- Shared package rv32i_types gains the enum muldiv_funct3_t (the 8 encodings) and the constant MULDIV_ITERS = 32. The control word gains the field muldiv_en.
- The state enum is local to the module.
- One sub-module is natural: muldiv_signfix, a combinational block that computes magnitudes and conditionally negates. It is instantiated once for the operands and once for the result.
- The iteration datapath stays inline with the FSM.

## Test plan
- MUL: a = 7, b = 6, start_i held → stall_o high for 34 cycles, then done_o with result_o = 42. MULHU with 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- Signed: MULH with −2 × 3 → 0xFFFFFFFF. MULHSU with a = 0xFFFFFFFF, b = 0xFFFFFFFF → 0xFFFFFFFF. DIV −7 / 2 → 0xFFFFFFFD. REM −7 / 2 → 0xFFFFFFFF.
- Special cases:
  - DIVU 5 / 0 → 0xFFFFFFFF, with done_o in cycle 1.
  - REM 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- Flush: assert flush_i in cycle 10 of a DIV → IDLE at the next edge, no done_o, stall_o low. A new MUL 3 × 3 then completes with result_o = 9.
- Back-to-back: DIVU 100 / 7 followed by REMU 100 / 7 → done_o pulses 35 cycles apart with results 14 and 2. No extra op is started from start_i during DONE.
- Reset: drive rst low in cycle 15 of a MUL → stall_o, done_o and result_o go to 0 immediately. After release, the op restarts from IDLE when start_i is seen.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: M-extension funct3 encodings,
// iteration count, and the decoded control word.
package rv32i_types;

    localparam int MULDIV_ITERS = 32;

    typedef enum logic [2:0] {
        F3_MUL    = 3'd0,
        F3_MULH   = 3'd1,
        F3_MULHSU = 3'd2,
        F3_MULHU  = 3'd3,
        F3_DIV    = 3'd4,
        F3_DIVU   = 3'd5,
        F3_REM    = 3'd6,
        F3_REMU   = 3'd7
    } muldiv_funct3_t;

    typedef struct packed {
        logic reg_we;
        logic mem_rd;
        logic mem_wr;
        logic alu_src;
        logic muldiv_en;
    } ctrl_word_t;

endpackage

// File: rtl/muldiv_signfix.sv
// Two-lane conditional two's-complement negation.
// Ports: x/y values in, neg_x/neg_y negate enables, fx/fy results out.
module muldiv_signfix #(
    parameter int WX = 32,
    parameter int WY = 32
) (
    input  logic [WX-1:0] x,
    input  logic          neg_x,
    input  logic [WY-1:0] y,
    input  logic          neg_y,
    output logic [WX-1:0] fx,
    output logic [WY-1:0] fy
);

    assign fx = neg_x ? -x : x;
    assign fy = neg_y ? -y : y;

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer beside the EX ALU.
// Ports: start_i/funct3_i/a_i/b_i op in, flush_i kill, stall_o, done_o, result_o.
module ex_muldiv_sequencer
    import rv32i_types::*;
#(
    parameter int WIDTH = MULDIV_ITERS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       funct3_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // MUL: {partial hi, multiplier}; DIV: {remainder, quotient}
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2:0]         f3_q, f3_d;
    logic               nq_q, nq_d;
    logic               nr_q, nr_d;
    logic [WIDTH-1:0]   res_q, res_d;

    logic             a_sgn, b_sgn, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        unique case (muldiv_funct3_t'(funct3_i))
            F3_MULH, F3_DIV, F3_REM: begin
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
            F3_MULHSU: a_sgn = 1'b1;
            default: ;
        endcase
    end

    assign a_neg = a_sgn & a_i[WIDTH-1];
    assign b_neg = b_sgn & b_i[WIDTH-1];

    muldiv_signfix #(.WX(WIDTH), .WY(WIDTH)) u_opfix (
        .x     (a_i),
        .neg_x (a_neg),
        .y     (b_i),
        .neg_y (b_neg),
        .fx    (a_mag),
        .fy    (b_mag)
    );

    logic [2*WIDTH-1:0] fix_x, fx;
    logic [WIDTH-1:0]   fy, sel;

    // Product negation spans the full double word (MULHSU high word).
    assign fix_x = f3_q[2] ? {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]} : acc_q;

    muldiv_signfix #(.WX(2*WIDTH), .WY(WIDTH)) u_resfix (
        .x     (fix_x),
        .neg_x (nq_q),
        .y     (acc_q[2*WIDTH-1:WIDTH]),
        .neg_y (nr_q),
        .fx    (fx),
        .fy    (fy)
    );

    always_comb begin
        sel = fy;
        unique case (muldiv_funct3_t'(f3_q))
            F3_MUL:                       sel = fx[WIDTH-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: sel = fx[2*WIDTH-1:WIDTH];
            F3_DIV, F3_DIVU:              sel = fx[WIDTH-1:0];
            default:                      sel = fy;
        endcase
    end

    logic [WIDTH:0]     mul_sum, rem_sh, diff;
    logic [2*WIDTH-1:0] mul_nxt, div_nxt;
    logic               last, ovf;

    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};
    assign rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign diff    = rem_sh - {1'b0, b_q};
    assign div_nxt = diff[WIDTH]
                   ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                   : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    assign last    = (cnt_q == CW'(WIDTH - 1));
    assign ovf     = a_sgn && (a_i == {1'b1, {(WIDTH-1){1'b0}}})
                   && (b_i == '1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        b_d     = b_q;
        f3_d    = f3_q;
        nq_d    = nq_q;
        nr_d    = nr_q;
        res_d   = res_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (start_i) begin
                    f3_d  = funct3_i;
                    b_d   = b_mag;
                    nq_d  = a_neg ^ b_neg;
                    nr_d  = a_neg;
                    cnt_d = '0;
                    acc_d = {{WIDTH{1'b0}}, a_mag};
                    if (!funct3_i[2]) begin
                        state_d = MUL;
                    end else if (b_i == '0) begin
                        res_d   = funct3_i[1] ? a_i : '1;
                        state_d = DONE;
                    end else if (ovf) begin
                        res_d   = funct3_i[1] ? '0 : a_i;
                        state_d = DONE;
                    end else begin
                        state_d = DIV;
                    end
                end
                MUL: begin
                    acc_d = mul_nxt;
                    cnt_d = cnt_q + 1'b1;
                    if (last) state_d = FIX;
                end
                DIV: begin
                    acc_d = div_nxt;
                    cnt_d = cnt_q + 1'b1;
                    if (last) state_d = FIX;
                end
                FIX: begin
                    res_d   = sel;
                    state_d = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            f3_q    <= '0;
            nq_q    <= 1'b0;
            nr_q    <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            f3_q    <= f3_d;
            nq_q    <= nq_d;
            nr_q    <= nr_d;
            res_q   <= res_d;
        end
    end

    // Reset gates stall so the pipeline is released while rst is held.
    assign stall_o  = rst & (((state_q == IDLE) & start_i & ~flush_i)
                    | (state_q == MUL) | (state_q == DIV)
                    | (state_q == FIX));
    assign done_o   = (state_q == DONE);
    assign result_o = res_q;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Self-checking bench for ex_muldiv_sequencer: directed and random
// RV32M ops checked every cycle against a 64-bit arithmetic model.
module tb_ex_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        flush_i = 1'b0;
    logic        stall_o, done_o;
    logic [31:0] result_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic        exp_stall  = 1'b0;
    logic        exp_done   = 1'b0;
    logic [31:0] exp_result = '0;

    ex_muldiv_sequencer #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .funct3_i (funct3_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0] ua, ub, up;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (f)
            3'd0: begin up = ua * ub; return up[31:0]; end
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * $signed(ub); return sp[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                sp = sa / sb;
                return sp[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                sp = sa % sb;
                return sp[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit special(input logic [2:0] f,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        if (!f[2]) return 1'b0;
        if (b == 0) return 1'b1;
        return (f == 3'd4 || f == 3'd6) && a == 32'h80000000
               && b == 32'hFFFFFFFF;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom();
        endcase
    endfunction

    // Per-cycle comparison of DUT outputs against the bench's expectation.
    always @(negedge clk) begin
        check("stall", 32'(stall_o), 32'(exp_stall));
        check("done", 32'(done_o), 32'(exp_done));
        check("result", result_o, exp_result);
    end

    task automatic idle(input int n);
        exp_stall = 1'b0;
        exp_done  = 1'b0;
        start_i   = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input bit pin_en,
                          input logic [31:0] pin);
        logic [31:0] r;
        int lat;
        r   = model(f, a, b);
        lat = special(f, a, b) ? 1 : 34;
        if (pin_en) check("model_pin", r, pin);
        start_i  = 1'b1;
        funct3_i = f;
        a_i      = a;
        b_i      = b;
        for (int k = 0; k <= lat; k++) begin
            exp_stall = (k < lat);
            exp_done  = (k == lat);
            if (k == lat) exp_result = r;
            @(negedge clk);
            if (k == lat && pin_en) check("pin_result", result_o, pin);
            @(posedge clk);
            #1;
        end
        start_i   = 1'b0;
        exp_stall = 1'b0;
        exp_done  = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", 32'(stall_o), 32'h0);
        check("rst_done", 32'(done_o), 32'h0);
        check("rst_result", result_o, 32'h0);
        rst = 1'b1;
        idle(2);

        run_op(3'd0, 32'd7, 32'd6, 1, 32'd42);
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE);
        run_op(3'd1, -32'd2, 32'd3, 1, 32'hFFFFFFFF);
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFF);
        run_op(3'd4, -32'd7, 32'd2, 1, 32'hFFFFFFFD);
        run_op(3'd6, -32'd7, 32'd2, 1, 32'hFFFFFFFF);
        idle(1);
        run_op(3'd5, 32'd5, 32'd0, 1, 32'hFFFFFFFF);
        run_op(3'd6, 32'd5, 32'd0, 1, 32'd5);
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000);
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 1, 32'h0);
        idle(1);
        run_op(3'd5, 32'd100, 32'd7, 1, 32'd14);
        run_op(3'd7, 32'd100, 32'd7, 1, 32'd2);
        idle(2);

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick(), 0, '0);
            if ($urandom_range(0, 2) == 0) idle(1);
        end
        idle(1);

        start_i  = 1'b1;
        funct3_i = 3'd4;
        a_i      = 32'd1000;
        b_i      = 32'd3;
        for (int k = 0; k <= 10; k++) begin
            exp_stall = 1'b1;
            exp_done  = 1'b0;
            if (k == 10) flush_i = 1'b1;
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        flush_i = 1'b0;
        idle(4);
        run_op(3'd0, 32'd3, 32'd3, 1, 32'd9);

        start_i  = 1'b1;
        funct3_i = 3'd0;
        a_i      = 32'd7;
        b_i      = 32'd6;
        for (int k = 0; k < 15; k++) begin
            exp_stall = 1'b1;
            exp_done  = 1'b0;
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        exp_stall  = 1'b0;
        exp_result = '0;
        #1;
        check("midrst_stall", 32'(stall_o), 32'h0);
        check("midrst_done", 32'(done_o), 32'h0);
        check("midrst_result", result_o, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);
        run_op(3'd0, 32'd7, 32'd6, 1, 32'd42);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
